// File: rtl/regalu_seq.sv
// rtl/regalu_seq.sv - 8085-style register file and byte/pair ALU behind a valid/ready command port
// Define REGALU_ROT_EN to enable the accumulator rotates (opcodes 16-19).
module regalu_seq #(
  parameter int         DATASIZE = 8,
  parameter int         PAIRSIZE = DATASIZE*2,
  parameter int         REGSBITS = 3,
  parameter logic [7:0] FLAGMASK = 8'b11010101
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                cmd_vld,
  output logic                cmd_rdy,
  input  logic [4:0]          cmd_op,
  input  logic [REGSBITS-1:0] cmd_dst,
  input  logic [REGSBITS-1:0] cmd_src,
  input  logic [DATASIZE-1:0] cmd_imm,
  output logic                done,
  output logic                err,
  output logic [DATASIZE-1:0] res_q,
  output logic [DATASIZE-1:0] flg_q,
  input  logic [REGSBITS-1:0] rd_addr,
  output logic [DATASIZE-1:0] rd_data,
  output logic [PAIRSIZE-1:0] sp_q
);
  localparam int NREGS = 1 << REGSBITS;
  localparam logic [REGSBITS-1:0] IDX_H = REGSBITS'(4);
  localparam logic [REGSBITS-1:0] IDX_L = REGSBITS'(5);
  localparam logic [REGSBITS-1:0] IDX_F = REGSBITS'(6);
  localparam logic [REGSBITS-1:0] IDX_A = REGSBITS'(7);
  localparam logic [DATASIZE-1:0] FMASK = DATASIZE'(FLAGMASK);
  localparam logic [DATASIZE-1:0] ONES  = {DATASIZE{1'b1}};
  localparam logic [DATASIZE-1:0] ZERO  = {DATASIZE{1'b0}};

  localparam logic [4:0] OP_ADD = 5'd0,  OP_ADC = 5'd1,  OP_SUB = 5'd2,  OP_SBB = 5'd3;
  localparam logic [4:0] OP_ANA = 5'd4,  OP_XRA = 5'd5,  OP_ORA = 5'd6,  OP_CMP = 5'd7;
  localparam logic [4:0] OP_INR = 5'd8,  OP_DCR = 5'd9,  OP_MOV = 5'd10, OP_MVI = 5'd11;
  localparam logic [4:0] OP_INX = 5'd12, OP_DCX = 5'd13, OP_DAD = 5'd14, OP_NOP = 5'd15;
`ifdef REGALU_ROT_EN
  localparam logic [4:0] OP_RLC = 5'd16, OP_RRC = 5'd17, OP_RAL = 5'd18, OP_RAR = 5'd19;
`endif

  typedef enum logic [1:0] {IDLE, EXB, EXLO, EXHI} state_t;
  state_t state_q, state_d;

  logic [4:0]          op_q;
  logic [REGSBITS-1:0] dst_q, src_q;
  logic [DATASIZE-1:0] imm_q;
  logic [DATASIZE-1:0] regs_q [NREGS];
  logic [DATASIZE-1:0] regs_d [NREGS];
  logic [PAIRSIZE-1:0] sp_d;
  logic [DATASIZE-1:0] res_d;
  logic                carry_q, carry_d;
  logic                done_q, done_d, err_q, err_d;

  logic [PAIRSIZE-1:0] pair_v [4];
  logic [PAIRSIZE-1:0] pd_v, ps_v;
  logic [DATASIZE-1:0] a_v, f_v, src_v, dst_v;
  logic [DATASIZE-1:0] add_a, add_b;
  logic                add_c;
  logic [DATASIZE:0]   sum;
  logic [4:0]          nib;
  logic                bad_op;
  logic [1:0]          wr_pair;

  function automatic logic [DATASIZE-1:0] mk_flags(input logic [DATASIZE-1:0] r,
                                                   input logic ac, input logic cy);
    logic [DATASIZE-1:0] f;
    f    = ZERO;
    f[7] = r[7];
    f[6] = (r == ZERO);
    f[4] = ac;
    f[2] = ~^r;
    f[0] = cy;
    return f & FMASK;
  endfunction

  assign pair_v[0] = {regs_q[0], regs_q[1]};
  assign pair_v[1] = {regs_q[2], regs_q[3]};
  assign pair_v[2] = {regs_q[IDX_H], regs_q[IDX_L]};
  assign pair_v[3] = sp_q;
  assign pd_v      = pair_v[dst_q[2:1]];
  assign ps_v      = pair_v[src_q[2:1]];
  assign wr_pair   = (op_q == OP_DAD) ? 2'd2 : dst_q[2:1];

  assign a_v   = regs_q[IDX_A];
  assign f_v   = regs_q[IDX_F];
  assign src_v = (src_q == IDX_F) ? imm_q : regs_q[src_q];
  assign dst_v = regs_q[dst_q];

  assign rd_data = regs_q[rd_addr];
  assign flg_q   = regs_q[IDX_F];

  // One adder serves byte arithmetic and both halves of the pair ops.
  always_comb begin
    add_a = ZERO;
    add_b = ZERO;
    add_c = 1'b0;
    case (state_q)
      EXB: begin
        case (op_q)
          OP_ADD:         begin add_a = a_v;   add_b = src_v;                      end
          OP_ADC:         begin add_a = a_v;   add_b = src_v;  add_c = f_v[0];     end
          OP_SUB, OP_CMP: begin add_a = a_v;   add_b = ~src_v; add_c = 1'b1;       end
          OP_SBB:         begin add_a = a_v;   add_b = ~src_v; add_c = ~f_v[0];    end
          OP_INR:         begin add_a = dst_v; add_c = 1'b1;                       end
          OP_DCR:         begin add_a = dst_v; add_b = ONES;                       end
          default: ;
        endcase
      end
      EXLO: begin
        add_a = (op_q == OP_DAD) ? regs_q[IDX_L] : pd_v[DATASIZE-1:0];
        add_b = (op_q == OP_DAD) ? ps_v[DATASIZE-1:0] : ((op_q == OP_DCX) ? ONES : ZERO);
        add_c = (op_q == OP_INX);
      end
      EXHI: begin
        add_a = (op_q == OP_DAD) ? regs_q[IDX_H] : pd_v[PAIRSIZE-1:DATASIZE];
        add_b = (op_q == OP_DAD) ? ps_v[PAIRSIZE-1:DATASIZE] : ((op_q == OP_DCX) ? ONES : ZERO);
        add_c = carry_q;
      end
      default: ;
    endcase
  end

  assign sum = {1'b0, add_a} + {1'b0, add_b} + (DATASIZE+1)'(add_c);
  assign nib = {1'b0, add_a[3:0]} + {1'b0, add_b[3:0]} + {4'd0, add_c};

  always_comb begin
    case (op_q)
      OP_INR, OP_DCR, OP_MOV, OP_MVI: bad_op = (dst_q == IDX_F);
`ifdef REGALU_ROT_EN
      OP_RLC, OP_RRC, OP_RAL, OP_RAR: bad_op = 1'b0;
`endif
      default:                        bad_op = (op_q > OP_NOP);
    endcase
  end

  always_comb begin
    regs_d  = regs_q;
    sp_d    = sp_q;
    res_d   = res_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      EXB: begin
        if (bad_op) begin
          err_d = 1'b1;
        end else begin
          done_d = 1'b1;
          case (op_q)
            OP_ADD, OP_ADC: begin
              res_d = sum[DATASIZE-1:0];
              regs_d[IDX_A] = res_d;
              regs_d[IDX_F] = mk_flags(res_d, nib[4], sum[DATASIZE]);
            end
            OP_SUB, OP_SBB, OP_CMP: begin
              res_d = sum[DATASIZE-1:0];
              if (op_q != OP_CMP) regs_d[IDX_A] = res_d;
              regs_d[IDX_F] = mk_flags(res_d, nib[4], ~sum[DATASIZE]);
            end
            OP_ANA: begin
              res_d = a_v & src_v;
              regs_d[IDX_A] = res_d;
              regs_d[IDX_F] = mk_flags(res_d, a_v[3] | src_v[3], 1'b0);
            end
            OP_XRA, OP_ORA: begin
              res_d = (op_q == OP_XRA) ? (a_v ^ src_v) : (a_v | src_v);
              regs_d[IDX_A] = res_d;
              regs_d[IDX_F] = mk_flags(res_d, 1'b0, 1'b0);
            end
            OP_INR, OP_DCR: begin
              res_d = sum[DATASIZE-1:0];
              regs_d[dst_q] = res_d;
              regs_d[IDX_F] = mk_flags(res_d, nib[4], f_v[0]);
            end
            OP_MOV, OP_MVI: begin
              res_d = (op_q == OP_MVI) ? imm_q : src_v;
              regs_d[dst_q] = res_d;
            end
`ifdef REGALU_ROT_EN
            OP_RLC, OP_RAL: begin
              res_d = {a_v[DATASIZE-2:0], (op_q == OP_RLC) ? a_v[DATASIZE-1] : f_v[0]};
              regs_d[IDX_A] = res_d;
              regs_d[IDX_F][0] = a_v[DATASIZE-1] & FMASK[0];
            end
            OP_RRC, OP_RAR: begin
              res_d = {(op_q == OP_RRC) ? a_v[0] : f_v[0], a_v[DATASIZE-1:1]};
              regs_d[IDX_A] = res_d;
              regs_d[IDX_F][0] = a_v[0] & FMASK[0];
            end
`endif
            default: ;
          endcase
        end
      end
      EXLO: begin
        res_d   = sum[DATASIZE-1:0];
        carry_d = sum[DATASIZE];
        if (wr_pair == 2'd3) sp_d[DATASIZE-1:0] = res_d;
        else                 regs_d[REGSBITS'({wr_pair, 1'b1})] = res_d;
      end
      EXHI: begin
        res_d  = sum[DATASIZE-1:0];
        done_d = 1'b1;
        if (wr_pair == 2'd3) sp_d[PAIRSIZE-1:DATASIZE] = res_d;
        else                 regs_d[REGSBITS'({wr_pair, 1'b0})] = res_d;
        if (op_q == OP_DAD)  regs_d[IDX_F][0] = sum[DATASIZE] & FMASK[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_vld)
              state_d = (cmd_op inside {OP_INX, OP_DCX, OP_DAD}) ? EXLO : EXB;
      EXB:  state_d = IDLE;
      EXLO: state_d = EXHI;
      EXHI: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_rdy = (state_q == IDLE);
    done    = done_q;
    err     = err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= ZERO;
      sp_q    <= '0;
      res_q   <= ZERO;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      op_q    <= 5'd0;
      dst_q   <= '0;
      src_q   <= '0;
      imm_q   <= ZERO;
    end else begin
      regs_q  <= regs_d;
      sp_q    <= sp_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (cmd_vld && cmd_rdy) begin
        op_q  <= cmd_op;
        dst_q <= cmd_dst;
        src_q <= cmd_src;
        imm_q <= cmd_imm;
      end
    end
  end

endmodule

// File: tb/tb_regalu_seq.sv
// tb/tb_regalu_seq.sv - directed self-checking bench for regalu_seq
// Build with REGALU_ROT_EN defined to exercise the rotate path instead of the err path.
module tb_regalu_seq;
  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       cmd_vld = 1'b0;
  logic       cmd_rdy;
  logic [4:0] cmd_op = '0;
  logic [2:0] cmd_dst = '0;
  logic [2:0] cmd_src = '0;
  logic [7:0] cmd_imm = '0;
  logic       done, err;
  logic [7:0] res_q, flg_q, rd_data;
  logic [2:0] rd_addr = '0;
  logic [15:0] sp_q;

  int n_tests = 0;
  int n_fail  = 0;

  always #50 clk = ~clk;

  regalu_seq dut (
    .clk(clk), .rst_(rst_), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
    .done(done), .err(err), .res_q(res_q), .flg_q(flg_q),
    .rd_addr(rd_addr), .rd_data(rd_data), .sp_q(sp_q)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    check(tag, rd_data, exp);
  endtask

  task automatic issue(input logic [4:0] op, input logic [2:0] dst, input logic [2:0] src,
                       input logic [7:0] imm);
    cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_imm = imm; cmd_vld = 1'b1;
    tick();
    cmd_vld = 1'b0;
  endtask

  // {done,err} must stay 00 until 'lat' edges after acceptance, then show done or err.
  task automatic run(input string tag, input logic [4:0] op, input logic [2:0] dst,
                     input logic [2:0] src, input logic [7:0] imm, input int lat,
                     input bit exp_err);
    issue(op, dst, src, imm);
    check({tag, "_busy"}, cmd_rdy, 1'b0);
    repeat (lat - 2) begin
      tick();
      check({tag, "_early"}, {done, err}, 2'b00);
    end
    tick();
    check({tag, "_end"}, {done, err}, exp_err ? 2'b01 : 2'b10);
  endtask

  initial begin
    rst_ = 1'b0;
    cmd_vld = 1'b1; cmd_op = 5'd11; cmd_dst = 3'd7; cmd_imm = 8'h55;
    tick();
    tick();
    rst_ = 1'b1;
    cmd_vld = 1'b0;
    check("rst_rdy", cmd_rdy, 1'b1);
    check("rst_pulse", {done, err}, 2'b00);
    for (int i = 0; i < 8; i++) check_reg("rst_reg", 3'(i), 8'h00);
    check("rst_sp", sp_q, 16'h0000);
    check("rst_res", res_q, 8'h00);
    tick();
    check("rst_quiet", {done, err}, 2'b00);

    run("mvi_a", 5'd11, 3'd7, 3'd0, 8'h3A, 2, 0);
    check_reg("mvi_a_val", 3'd7, 8'h3A);
    check("mvi_flags", flg_q, 8'h00);
    run("add_imm", 5'd0, 3'd7, 3'd6, 8'hC6, 2, 0);
    check_reg("add_a", 3'd7, 8'h00);
    check("add_f", flg_q, 8'h55);

    run("mvi_h", 5'd11, 3'd4, 3'd0, 8'hFF, 2, 0);
    run("mvi_l", 5'd11, 3'd5, 3'd0, 8'hFF, 2, 0);
    issue(5'd12, 3'd4, 3'd0, 8'h00);
    check("inx_busy", cmd_rdy, 1'b0);
    cmd_op = 5'd11; cmd_dst = 3'd7; cmd_imm = 8'h77; cmd_vld = 1'b1;
    tick();
    check("inx_lo", {done, err, cmd_rdy}, 3'b000);
    tick();
    check("inx_end", {done, err}, 2'b10);
    cmd_vld = 1'b0;
    check_reg("inx_h", 3'd4, 8'h00);
    check_reg("inx_l", 3'd5, 8'h00);
    check("inx_f", flg_q, 8'h55);
    tick();
    check("inx_noqueue", {done, err}, 2'b00);
    check_reg("inx_a_kept", 3'd7, 8'h00);

    run("ora_clr", 5'd6, 3'd7, 3'd6, 8'h00, 2, 0);
    check("ora_f", flg_q, 8'h44);
    run("mvi_h2", 5'd11, 3'd4, 3'd0, 8'h80, 2, 0);
    run("mvi_l2", 5'd11, 3'd5, 3'd0, 8'h01, 2, 0);
    run("mvi_b", 5'd11, 3'd0, 3'd0, 8'h80, 2, 0);
    run("mvi_c", 5'd11, 3'd1, 3'd0, 8'h00, 2, 0);
    run("dad_bc", 5'd14, 3'd4, 3'd0, 8'h00, 3, 0);
    check_reg("dad_h", 3'd4, 8'h00);
    check_reg("dad_l", 3'd5, 8'h01);
    check("dad_f", flg_q, 8'h45);

    run("mov_f", 5'd10, 3'd6, 3'd7, 8'h00, 2, 1);
    check("mov_f_flags", flg_q, 8'h45);
    check("mov_f_res", res_q, 8'h00);
    run("nop", 5'd15, 3'd7, 3'd6, 8'hAA, 2, 0);
    check("nop_f", flg_q, 8'h45);
    check_reg("nop_a", 3'd7, 8'h00);
    check_reg("nop_l", 3'd5, 8'h01);

    run("mvi_a2", 5'd11, 3'd7, 3'd0, 8'h10, 2, 0);
    run("sub_imm", 5'd2, 3'd7, 3'd6, 8'h20, 2, 0);
    check_reg("sub_a", 3'd7, 8'hF0);
    check("sub_f", flg_q, 8'h95);

    run("mvi_a3", 5'd11, 3'd7, 3'd0, 8'hFF, 2, 0);
    run("inr_a", 5'd8, 3'd7, 3'd0, 8'h00, 2, 0);
    check_reg("inr_a_val", 3'd7, 8'h00);
    check("inr_f", flg_q, 8'h55);

    run("mvi_a4", 5'd11, 3'd7, 3'd0, 8'h05, 2, 0);
    run("cmp_eq", 5'd7, 3'd7, 3'd6, 8'h05, 2, 0);
    check_reg("cmp_a_kept", 3'd7, 8'h05);
    check("cmp_f", flg_q, 8'h54);
    check("cmp_res", res_q, 8'h00);

    run("dcx_sp", 5'd13, 3'd6, 3'd0, 8'h00, 3, 0);
    check("dcx_sp_val", sp_q, 16'hFFFF);
    check("dcx_f", flg_q, 8'h54);

    run("undef_op", 5'd31, 3'd7, 3'd6, 8'hAA, 2, 1);
    check_reg("undef_a", 3'd7, 8'h05);
    check("undef_f", flg_q, 8'h54);

    run("mvi_a5", 5'd11, 3'd7, 3'd0, 8'h81, 2, 0);
    run("ora_81", 5'd6, 3'd7, 3'd6, 8'h00, 2, 0);
    check("ora_81_f", flg_q, 8'h84);
`ifdef REGALU_ROT_EN
    run("rlc", 5'd16, 3'd7, 3'd0, 8'h00, 2, 0);
    check_reg("rlc_a", 3'd7, 8'h03);
    check("rlc_f", flg_q, 8'h85);
`else
    run("rlc_off", 5'd16, 3'd7, 3'd0, 8'h00, 2, 1);
    check_reg("rlc_off_a", 3'd7, 8'h81);
    check("rlc_off_f", flg_q, 8'h84);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
